// File: rtl/branch_flow_pkg.sv
// Shared constants and types for the branch flow controller.
package branch_flow_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = bht_cnt_t'(cnt + 2'd1);
        end else begin
            if (cnt != SNT) nxt = bht_cnt_t'(cnt - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_flow_controller_bht.sv
// Branch history table: 2-bit saturating counters, async read, sync update.
module branch_history_table
    import branch_flow_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_t bht_q [ENTRIES];
    bht_cnt_t bht_d [ENTRIES];

    // Read sees the pre-update value when it hits the entry being written.
    assign rd_cnt = bht_q[rd_idx];

    always_comb begin
        bht_d = bht_q;
        if (wr_en) begin
            bht_d[wr_idx] = bht_next(bht_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

endmodule

// File: rtl/branch_flow_controller.sv
// Pipeline control-flow sequencer: ID prediction, EX resolution, flush/stall, event counters.
module branch_flow_controller
    import branch_flow_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic [31:0]      id_target,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jalr,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    output logic             id_pred_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             stall_fetch,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    bht_cnt_t    rd_cnt;
    logic        mis;
    logic        lu;
    logic        ex_resolve;
    logic [31:0] correct_pc;
    logic        unused_pc_bits;

    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    assign unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (id_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (ex_valid & ex_is_branch),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    assign id_pred_taken = id_valid &
                           (id_is_jal | (id_is_branch & ((rd_cnt == WT) | (rd_cnt == ST))));

    assign mis = ex_valid & ((ex_is_branch & (ex_taken != ex_pred_taken)) | ex_is_jalr);
    assign lu  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign ex_resolve = ex_valid & (ex_is_branch | ex_is_jalr);
    assign correct_pc = (ex_taken | ex_is_jalr) ? ex_target : ex_pc + 32'd4;

    // Mispredict beats load-use beats ID redirect; a stalled ID redirect simply re-fires later.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        stall_fetch = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst_n) begin
            if (mis) begin
                redirect    = 1'b1;
                redirect_pc = correct_pc;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (lu) begin
                stall_fetch = 1'b1;
                flush_id_ex = 1'b1;
            end else if (id_pred_taken) begin
                redirect    = 1'b1;
                redirect_pc = id_target;
                flush_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_resolve && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (mis && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_flow_controller.sv
// Directed scoreboard bench for branch_flow_controller (16-entry BHT, 4-bit counters).
module tb_branch_flow_controller;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, id_is_branch, id_is_jal;
    logic [31:0]      id_pc, id_target;
    logic [4:0]       id_rs1, id_rs2;
    logic             ex_valid, ex_is_branch, ex_is_jalr, ex_taken, ex_pred_taken;
    logic [31:0]      ex_pc, ex_target;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             id_pred_taken, redirect, stall_fetch, flush_if_id, flush_id_ex;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_b  = 0;
    int   exp_m  = 0;

    branch_flow_controller #(
        .BHT_ENTRIES (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_is_branch     (id_is_branch),
        .id_is_jal        (id_is_jal),
        .id_target        (id_target),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jalr       (ex_is_jalr),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .id_pred_taken    (id_pred_taken),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .stall_fetch      (stall_fetch),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = '0; id_is_branch = 0; id_is_jal = 0; id_target = '0;
        id_rs1 = '0; id_rs2 = '0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jalr = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = '0; ex_target = '0; ex_mem_read = 0; ex_rd = '0;
    endtask

    // Expectations are queued with the stimulus; control is sampled mid-cycle, counters after the edge.
    task automatic run_step(input string tag, input logic pred, input logic redir,
                            input logic [31:0] rpc, input logic stall,
                            input logic fif, input logic fie, input bit chk_cnt);
        push({tag, ".pred"},  {31'd0, pred});
        push({tag, ".redir"}, {31'd0, redir});
        push({tag, ".rpc"},   rpc);
        push({tag, ".stall"}, {31'd0, stall});
        push({tag, ".fif"},   {31'd0, fif});
        push({tag, ".fie"},   {31'd0, fie});
        if (chk_cnt) begin
            push({tag, ".bcnt"}, 32'(exp_b));
            push({tag, ".mcnt"}, 32'(exp_m));
        end
        @(negedge clk);
        cmp({31'd0, id_pred_taken});
        cmp({31'd0, redirect});
        cmp(redirect_pc);
        cmp({31'd0, stall_fetch});
        cmp({31'd0, flush_if_id});
        cmp({31'd0, flush_id_ex});
        @(posedge clk);
        #1;
        if (chk_cnt) begin
            cmp(32'(branch_count));
            cmp(32'(mispredict_count));
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    initial begin
        clear_inputs();
        rst_n = 0;
        id_valid = 1; id_pc = 32'h40; id_rs1 = 5; id_target = 32'h80;
        ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 0;
        ex_pc = 32'h40; ex_target = 32'h80; ex_mem_read = 1; ex_rd = 5;
        run_step("reset0", 0, 0, 0, 0, 0, 0, 1);
        run_step("reset1", 0, 0, 0, 0, 0, 0, 1);

        rst_n = 1;
        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80;
        run_step("post_reset_pred", 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 0;
            ex_pc = 32'h40; ex_target = 32'h80;
            exp_b = sat(exp_b); exp_m = sat(exp_m);
            run_step("train", 0, 1, 32'h80, 0, 1, 1, 1);
        end

        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80;
        run_step("trained_pred", 1, 1, 32'h80, 0, 1, 0, 1);

        id_pc = 32'h80; id_target = 32'h100;
        run_step("alias_80", 1, 1, 32'h100, 0, 1, 0, 1);
        id_pc = 32'h44; id_target = 32'h90;
        run_step("alias_44", 0, 0, 0, 0, 0, 0, 1);

        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80;
        id_rs1 = 3; id_rs2 = 5;
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        run_step("load_use", 1, 0, 0, 1, 0, 1, 1);
        ex_rd = 0;
        run_step("load_use_x0", 1, 1, 32'h80, 0, 1, 0, 1);

        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80; id_rs1 = 5;
        ex_valid = 1; ex_is_branch = 1; ex_taken = 0; ex_pred_taken = 1;
        ex_pc = 32'h100; ex_target = 32'h200; ex_mem_read = 1; ex_rd = 5;
        exp_b = sat(exp_b); exp_m = sat(exp_m);
        run_step("simultaneous", 1, 1, 32'h104, 0, 1, 1, 1);

        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80;
        ex_valid = 1; ex_is_branch = 1; ex_taken = 0; ex_pred_taken = 1;
        ex_pc = 32'h40; ex_target = 32'h80;
        exp_b = sat(exp_b); exp_m = sat(exp_m);
        run_step("collision_old", 1, 1, 32'h44, 0, 1, 1, 1);
        clear_inputs();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_target = 32'h80;
        run_step("collision_new", 0, 0, 0, 0, 0, 0, 1);

        clear_inputs();
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h300; ex_target = 32'h200;
        exp_b = sat(exp_b); exp_m = sat(exp_m);
        run_step("jalr", 0, 1, 32'h200, 0, 1, 1, 1);

        clear_inputs();
        ex_valid = 1; ex_is_branch = 1; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 32'h44; ex_target = 32'h90;
        for (int i = 0; i < 20; i++) begin
            exp_b = sat(exp_b);
            run_step("sat_branch", 0, 0, 0, 0, 0, 0, 1);
        end

        clear_inputs();
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h300; ex_target = 32'h204;
        exp_b = sat(exp_b); exp_m = sat(exp_m);
        run_step("jalr_sat", 0, 1, 32'h204, 0, 1, 1, 1);

        clear_inputs();
        ex_valid = 1; ex_is_branch = 1; ex_taken = 0; ex_pred_taken = 1;
        ex_pc = 32'hFFFF_FFFC; ex_target = 32'h10;
        exp_b = sat(exp_b); exp_m = sat(exp_m);
        run_step("pc_wrap", 0, 1, 32'h0, 0, 1, 1, 1);

        rst_n = 0;
        exp_b = 0; exp_m = 0;
        run_step("reset_mid_redirect", 0, 0, 0, 0, 0, 0, 1);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_flow_controller.md
Name: branch_flow_controller

Overview:
- Sequences control flow for the RV32I five-stage pipeline.
- Predicts branches in ID with a table of 2-bit saturating counters, and redirects the PC on a predicted-taken branch or JAL.
- Resolves in EX using the taken flag from the branch comparator. Issues the mispredict redirect, the pipeline flushes and the load-use stall.
- Keeps branch and mispredict event counters.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, minimum 2.
- CNT_W, 32, width of each event counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_is_branch  in  1  ID opcode is 1100011
- id_is_jal  in  1  ID opcode is 1101111
- id_target  in  32  id_pc + immediate, computed in ID
- id_rs1, id_rs2  in  5 each  ID source register indices
- ex_valid  in  1  EX stage holds a real instruction
- ex_is_branch  in  1  EX opcode is 1100011
- ex_is_jalr  in  1  EX opcode is 1100111
- ex_taken  in  1  branch comparator result for the EX instruction
- ex_pred_taken  in  1  prediction carried down the pipe from ID
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  resolved target (branch target, or JALR address with bit 0 cleared)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- id_pred_taken  out  1  prediction for the ID instruction
- redirect  out  1  PC loads redirect_pc at the next edge
- redirect_pc  out  32  redirect address
- stall_fetch  out  1  hold PC and the IF/ID register
- flush_if_id  out  1  squash IF/ID
- flush_id_ex  out  1  insert a bubble into ID/EX
- branch_count  out  CNT_W  resolved branches plus JALRs, registered
- mispredict_count  out  CNT_W  mispredicts, registered

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1:2].
- Prediction: id_pred_taken = id_valid & (id_is_jal | (id_is_branch & bht[idx(id_pc)][1])). Combinational from table state.
- Mispredict: mis = ex_valid & ((ex_is_branch & (ex_taken != ex_pred_taken)) | ex_is_jalr).
- Correct PC: (ex_taken | ex_is_jalr) ? ex_target : ex_pc + 4, wrapping modulo 2^32.
- Load-use: lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Control outputs are combinational, same cycle as the cause. Redirect takes effect at the next edge (zero-cycle decision, one bubble per flushed stage).
- Priority, highest first:
  1. mis: redirect=1, redirect_pc=correct PC, flush_if_id=1, flush_id_ex=1, stall_fetch=0.
  2. lu: stall_fetch=1, flush_id_ex=1, redirect=0. An ID predicted-taken redirect is deferred until the stall clears.
  3. id_pred_taken: redirect=1, redirect_pc=id_target, flush_if_id=1.
  4. Otherwise all control outputs are 0 and redirect_pc=0.
- BHT update at the edge when ex_valid & ex_is_branch: taken increments, not-taken decrements, saturating. Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- BHT read/write collision: a same-cycle read of the entry being updated returns the old value; no bypass.
- Counters: branch_count increments on ex_valid & (ex_is_branch | ex_is_jalr); mispredict_count increments on mis. Both saturate at all-ones.
- Reset while rst_n=0:
  - All BHT entries set to 01; both counters set to 0.
  - All control outputs forced to 0 regardless of inputs.
  - A reset asserted mid-redirect discards the redirect.

Decomposition:
- Package branch_flow_pkg holds: opcode constants OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111; counter encodings SNT/WNT/WT/ST; a typedef for the 2-bit counter.
- One sub-module, branch_history_table: counter array, combinational read port, synchronous saturating update port, synchronous reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ex_valid=1, mis conditions and lu conditions asserted. Required: redirect, stall_fetch, both flushes and both counters = 0. After release, an ID branch at 0x40 gives id_pred_taken=0.
- Training: EX branch ex_pc=0x40, ex_taken=1, ex_pred_taken=0, ex_target=0x80. Required: redirect=1, redirect_pc=0x80, both flushes=1, mispredict_count=1. Repeat once more; then ID branch id_pc=0x40, id_target=0x80 gives id_pred_taken=1, redirect_pc=0x80, flush_if_id=1, flush_id_ex=0.
- Aliasing: with BHT_ENTRIES=16, train 0x40 to 11. Required: ID branch at 0x80 (same idx 0) predicts taken; ID branch at 0x44 predicts not-taken.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5. Required: stall_fetch=1, flush_id_ex=1, redirect=0. Repeat with ex_rd=0: no stall.
- Simultaneous events: EX branch ex_pc=0x100, ex_pred_taken=1, ex_taken=0, plus lu and an ID predicted-taken branch. Required: redirect_pc=0x104, both flushes=1, stall_fetch=0.
- Saturation: CNT_W=4, 20 resolved branches. Required: branch_count=15 and holds; a JALR counts as a branch and as a mispredict.
